// File: rtl/fsm_seq_decoder_if.sv
// Sample/status bundle between the decoder and whatever drives it.
//   en        : sample strobe (driver -> decoder)
//   y[1:0]    : generator FSM state code (driver -> decoder)
//   clear     : clears err_flag and burst_cnt (driver -> decoder)
//   locked    : decoder is tracking a legal sequence (decoder -> driver)
//   w_rec     : recovered w bit (decoder -> driver)
//   w_valid   : one-cycle pulse, a w decision was decoded
//   err       : one-cycle pulse, illegal transition seen
//   err_flag  : sticky error
//   burst_cnt : completed 10->11->01 bursts, wraps modulo 2^CNT_W
interface fsm_seq_decoder_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       y;
  logic             clear;
  logic             locked;
  logic             w_rec;
  logic             w_valid;
  logic             err;
  logic             err_flag;
  logic [CNT_W-1:0] burst_cnt;

  modport master (
    output en, y, clear,
    input  locked, w_rec, w_valid, err, err_flag, burst_cnt
  );

  modport slave (
    input  en, y, clear,
    output locked, w_rec, w_valid, err, err_flag, burst_cnt
  );
endinterface

// File: rtl/fsm_seq_decoder.sv
// Receive-side tracker for the 2-bit JK sequence generator. It follows the
// generator's y stream in lockstep, recovers the w bit behind each decision,
// counts completed 10->11->01 bursts and flags illegal transitions.
// Ports:
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset, priority over everything
//   bus : fsm_seq_decoder_if.slave (en, y, clear in; status out)
// All outputs are registered; a sample taken at edge N shows after edge N.
module fsm_seq_decoder #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm_seq_decoder_if.slave     bus
);

  typedef enum logic [2:0] {
    UNSYNC = 3'd0,
    S00    = 3'd1,
    S10    = 3'd2,
    S11    = 3'd3,
    S01    = 3'd4
  } state_t;

  state_t           state_q,    state_d;
  logic             locked_q,   locked_d;
  logic             w_rec_q,    w_rec_d;
  logic             w_valid_q,  w_valid_d;
  logic             err_q,      err_d;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  always_comb begin
    state_d    = state_q;
    w_rec_d    = w_rec_q;
    w_valid_d  = 1'b0;
    err_d      = 1'b0;
    err_flag_d = err_flag_q;
    cnt_d      = cnt_q;

    if (bus.en) begin
      unique case (state_q)
        UNSYNC: begin
          // Only a 00 sample gives a known phase; anything else is ignored.
          if (bus.y == 2'b00) state_d = S00;
        end
        S00, S01: begin
          // Decision points: the next code reveals the w bit that was applied.
          if (bus.y == 2'b00) begin
            state_d   = S00;
            w_rec_d   = 1'b0;
            w_valid_d = 1'b1;
          end else if (bus.y == 2'b10) begin
            state_d   = S10;
            w_rec_d   = 1'b1;
            w_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        S10: begin
          if (bus.y == 2'b11) state_d = S11;
          else                err_d   = 1'b1;
        end
        S11: begin
          if (bus.y == 2'b01) begin
            state_d = S01;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = UNSYNC;
      endcase

      // The offending sample is dropped; relock waits for a later 00.
      if (err_d) begin
        state_d    = UNSYNC;
        err_flag_d = 1'b1;
      end
    end

    // clear beats a same-cycle increment but loses to a same-cycle error.
    if (bus.clear) begin
      cnt_d      = '0;
      err_flag_d = err_d;
    end

    locked_d = (state_d != UNSYNC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNSYNC;
      locked_q   <= 1'b0;
      w_rec_q    <= 1'b0;
      w_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      locked_q   <= locked_d;
      w_rec_q    <= w_rec_d;
      w_valid_q  <= w_valid_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.w_rec     = w_rec_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.err       = err_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.burst_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_seq_decoder.sv
// Directed bench for fsm_seq_decoder: a CNT_W=8 instance and a CNT_W=2
// instance see identical stimulus; the narrow one exercises counter wrap.
module tb_fsm_seq_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fsm_seq_decoder_if #(.CNT_W(8)) ifw ();
  fsm_seq_decoder_if #(.CNT_W(2)) ifn ();

  fsm_seq_decoder #(.CNT_W(8)) dut_w (.clk(clk), .rst(rst), .bus(ifw));
  fsm_seq_decoder #(.CNT_W(2)) dut_n (.clk(clk), .rst(rst), .bus(ifn));

  // Apply one sample to both instances and sample outputs 1 time unit after the edge.
  task automatic step(input logic e, input logic [1:0] yy, input logic c);
    ifw.en = e; ifw.y = yy; ifw.clear = c;
    ifn.en = e; ifn.y = yy; ifn.clear = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 2'b00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 2'b10, 1'b1);
    tests++; if ({ifw.locked, ifw.w_rec, ifw.w_valid, ifw.err, ifw.err_flag} !== 5'b0 || ifw.burst_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_outputs got lk/wr/wv/er/ef=%b cnt=%0d exp 00000 cnt=0",
        {ifw.locked, ifw.w_rec, ifw.w_valid, ifw.err, ifw.err_flag}, ifw.burst_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [1:0] ys [6] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    logic       ev [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       er [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ys[i], 1'b0);
      tests++; if (ifw.locked !== 1'b1 || ifw.err !== 1'b0) begin
        fails++; $display("FAIL basic_lock[%0d] locked=%b err=%b exp 1 0", i, ifw.locked, ifw.err); end
      tests++; if (ifw.w_valid !== ev[i] || (ev[i] && ifw.w_rec !== er[i])) begin
        fails++; $display("FAIL basic_w[%0d] w_valid=%b w_rec=%b exp %b %b", i, ifw.w_valid, ifw.w_rec, ev[i], er[i]); end
    end
    tests++; if (ifw.burst_cnt !== 8'd1) begin
      fails++; $display("FAIL basic_cnt burst_cnt=%0d exp 1", ifw.burst_cnt); end
  endtask

  task automatic test_unlocked();
    logic [1:0] ys [3] = '{2'b11, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ys[i], 1'b0);
      tests++; if (ifw.locked !== 1'b0 || ifw.err !== 1'b0 || ifw.w_valid !== 1'b0) begin
        fails++; $display("FAIL unlocked[%0d] locked=%b err=%b wv=%b exp 0 0 0", i, ifw.locked, ifw.err, ifw.w_valid); end
    end
    step(1'b1, 2'b00, 1'b0);
    tests++; if (ifw.locked !== 1'b1 || ifw.w_valid !== 1'b0) begin
      fails++; $display("FAIL unlocked_relock locked=%b wv=%b exp 1 0", ifw.locked, ifw.w_valid); end
  endtask

  task automatic test_illegal();
    step(1'b1, 2'b10, 1'b0);        // S00 -> S10, w_rec=1
    step(1'b1, 2'b00, 1'b0);        // illegal from S10
    tests++; if (ifw.err !== 1'b1 || ifw.err_flag !== 1'b1 || ifw.locked !== 1'b0 || ifw.w_valid !== 1'b0 || ifw.w_rec !== 1'b1) begin
      fails++; $display("FAIL illegal_err err=%b ef=%b lk=%b wv=%b wr=%b exp 1 1 0 0 1",
        ifw.err, ifw.err_flag, ifw.locked, ifw.w_valid, ifw.w_rec); end
    step(1'b1, 2'b10, 1'b0);
    tests++; if (ifw.err !== 1'b0 || ifw.locked !== 1'b0 || ifw.w_valid !== 1'b0) begin
      fails++; $display("FAIL illegal_ignore err=%b lk=%b wv=%b exp 0 0 0", ifw.err, ifw.locked, ifw.w_valid); end
    step(1'b1, 2'b00, 1'b0);
    tests++; if (ifw.locked !== 1'b1 || ifw.err_flag !== 1'b1 || ifw.err !== 1'b0) begin
      fails++; $display("FAIL illegal_relock lk=%b ef=%b err=%b exp 1 1 0", ifw.locked, ifw.err_flag, ifw.err); end
  endtask

  task automatic test_wrap();
    logic [1:0] expn [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int b = 0; b < 5; b++) begin
      step(1'b1, 2'b00, 1'b0);
      step(1'b1, 2'b10, 1'b0);
      step(1'b1, 2'b11, 1'b0);
      step(1'b1, 2'b01, 1'b0);
      tests++; if (ifn.burst_cnt !== expn[b] || ifn.err !== 1'b0) begin
        fails++; $display("FAIL wrap_narrow[%0d] burst_cnt=%0d err=%b exp %0d 0", b, ifn.burst_cnt, ifn.err, expn[b]); end
      tests++; if (ifw.burst_cnt !== 8'(b + 1)) begin
        fails++; $display("FAIL wrap_wide[%0d] burst_cnt=%0d exp %0d", b, ifw.burst_cnt, b + 1); end
    end
  endtask

  task automatic test_en_gating();
    logic [1:0] ys [3] = '{2'b11, 2'b00, 2'b11};
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b10, 1'b0);        // now in S10, cnt=5
    for (int i = 0; i < 3; i++) begin
      step(1'b0, ys[i], 1'b0);
      tests++; if (ifw.w_valid !== 1'b0 || ifw.err !== 1'b0 || ifw.locked !== 1'b1 || ifw.w_rec !== 1'b1 || ifw.burst_cnt !== 8'd5) begin
        fails++; $display("FAIL en_hold[%0d] wv=%b err=%b lk=%b wr=%b cnt=%0d exp 0 0 1 1 5",
          i, ifw.w_valid, ifw.err, ifw.locked, ifw.w_rec, ifw.burst_cnt); end
    end
    step(1'b1, 2'b11, 1'b0);
    tests++; if (ifw.err !== 1'b0 || ifw.locked !== 1'b1) begin
      fails++; $display("FAIL en_resume err=%b lk=%b exp 0 1", ifw.err, ifw.locked); end
    step(1'b1, 2'b01, 1'b0);
    tests++; if (ifw.burst_cnt !== 8'd6) begin
      fails++; $display("FAIL en_resume_cnt burst_cnt=%0d exp 6", ifw.burst_cnt); end
  endtask

  task automatic test_clear_rst();
    step(1'b1, 2'b10, 1'b0);        // S01 -> S10
    step(1'b1, 2'b01, 1'b1);        // error with clear in same cycle
    tests++; if (ifw.err !== 1'b1 || ifw.err_flag !== 1'b1 || ifw.burst_cnt !== 8'd0) begin
      fails++; $display("FAIL clear_err err=%b ef=%b cnt=%0d exp 1 1 0", ifw.err, ifw.err_flag, ifw.burst_cnt); end
    step(1'b0, 2'b00, 1'b1);
    tests++; if (ifw.err_flag !== 1'b0 || ifw.locked !== 1'b0) begin
      fails++; $display("FAIL clear_only ef=%b lk=%b exp 0 0", ifw.err_flag, ifw.locked); end
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b01, 1'b1);        // increment lost to clear
    tests++; if (ifw.burst_cnt !== 8'd0 || ifw.locked !== 1'b1 || ifw.err !== 1'b0) begin
      fails++; $display("FAIL clear_inc cnt=%0d lk=%b err=%b exp 0 1 0", ifw.burst_cnt, ifw.locked, ifw.err); end
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b11, 1'b0);        // S11, w_rec=1, cnt=0
    step(1'b1, 2'b01, 1'b0);        // cnt=1
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b11, 1'b0);        // S11 again
    rst = 1'b1;
    step(1'b1, 2'b01, 1'b0);
    rst = 1'b0;
    tests++; if ({ifw.locked, ifw.w_rec, ifw.w_valid, ifw.err, ifw.err_flag} !== 5'b0 || ifw.burst_cnt !== 8'd0) begin
      fails++; $display("FAIL rst_midburst lk/wr/wv/er/ef=%b cnt=%0d exp 00000 0",
        {ifw.locked, ifw.w_rec, ifw.w_valid, ifw.err, ifw.err_flag}, ifw.burst_cnt); end
    step(1'b1, 2'b01, 1'b0);
    tests++; if (ifw.locked !== 1'b0 || ifw.err !== 1'b0) begin
      fails++; $display("FAIL rst_unsync lk=%b err=%b exp 0 0", ifw.locked, ifw.err); end
    step(1'b1, 2'b00, 1'b0);
    tests++; if (ifw.locked !== 1'b1) begin
      fails++; $display("FAIL rst_relock lk=%b exp 1", ifw.locked); end
  endtask

  initial begin
    ifw.en = 1'b0; ifw.y = 2'b00; ifw.clear = 1'b0;
    ifn.en = 1'b0; ifn.y = 2'b00; ifn.clear = 1'b0;
    test_reset();
    test_basic();
    test_unlocked();
    test_illegal();
    test_wrap();
    test_en_gating();
    test_clear_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
